// File: rtl/inst_fetch.sv
// inst_fetch: RV32I instruction fetch stage, upstream of decode.
//
// Issues word reads to instruction memory over a req/gnt/rvalid handshake,
// buffers returned words with their PC in a small prefetch FIFO and presents
// the FIFO head to decode. A redirect flushes the FIFO and arranges for every
// response still in flight to be dropped when it arrives.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rstB         synchronous reset, active-low
//   imem_req     fetch request
//   imem_addr    fetch word address, bits [1:0] always 0
//   imem_gnt     request accepted this cycle
//   imem_rvalid  read data valid (in-order responses)
//   imem_rdata   read data
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch PC, bits [1:0] ignored
//   stall        downstream not accepting; hold the FIFO head
//   instr_valid  FIFO non-empty
//   instr_out    FIFO head word, NOP_INSTR when instr_valid=0
//   instr_pc     PC of instr_out, 0 when instr_valid=0
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstB,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // wide enough to hold cnt+osd+stl without overflow
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

  // word-aligned PC, low two bits implicit zero
  logic [29:0]   pc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] osd;
  logic [CW-1:0] stl;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pq_rd;
  logic [AW-1:0] pq_wr;

  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_word [FIFO_DEPTH];
  // PCs of granted requests whose responses are still expected, in order
  logic [31:0]   pq        [FIFO_DEPTH];

  logic [SW-1:0] credit_used;
  logic          fire;
  logic          push;
  logic          drop_stale;
  logic          pop;
  logic          unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  // Every granted request reserves a FIFO slot until its word is consumed
  // or it is known stale, so a push can never find the FIFO full.
  assign credit_used = SW'(cnt) + SW'(osd) + SW'(stl);
  assign imem_req    = rstB & ~redirect & (credit_used < DEPTH_S);
  assign imem_addr   = {pc, 2'b00};

  assign fire        = imem_req & imem_gnt;
  assign push        = imem_rvalid & ~redirect & (stl == '0);
  assign drop_stale  = imem_rvalid & ~redirect & (stl != '0);
  assign instr_valid = (cnt != '0);
  assign pop         = instr_valid & ~stall & ~redirect;

  assign instr_out   = instr_valid ? fifo_word[rd_ptr] : NOP_INSTR;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (!rstB) begin
      pc     <= RESET_PC[31:2];
      cnt    <= '0;
      osd    <= '0;
      stl    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      pq_rd  <= '0;
      pq_wr  <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc[31:2];
      cnt    <= '0;
      osd    <= '0;
      // everything in flight becomes stale; an rvalid this cycle retires one
      stl    <= stl + osd - CW'(imem_rvalid);
      rd_ptr <= '0;
      wr_ptr <= '0;
      pq_rd  <= '0;
      pq_wr  <= '0;
    end else begin
      if (fire) begin
        pc    <= pc + 30'd1;
        pq_wr <= pq_wr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        pq_rd  <= pq_rd + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      osd <= osd + CW'(fire) - CW'(push);
      stl <= stl - CW'(drop_stale);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // storage arrays carry no reset; occupancy and pointers qualify them
  always_ff @(posedge clk) begin
    if (fire) begin
      pq[pq_wr] <= {pc, 2'b00};
    end
    if (push) begin
      fifo_pc[wr_ptr]   <= pq[pq_rd];
      fifo_word[wr_ptr] <= imem_rdata;
    end
  end

  a_credit : assert property (@(posedge clk) disable iff (!rstB)
    credit_used <= DEPTH_S);
  a_rvalid : assert property (@(posedge clk) disable iff (!rstB)
    imem_rvalid |-> ((SW'(osd) + SW'(stl)) != '0));
  a_nop : assert property (@(posedge clk) disable iff (!rstB)
    !instr_valid |-> (instr_out == NOP_INSTR));

endmodule
